// File: rtl/msk_gf_pkg.sv
// Shared constants and index helpers for the masked GF(2^W) multiplier family.
package msk_gf_pkg;

    localparam logic [2:0] GF4_POLY   = 3'h7;
    localparam logic [4:0] GF16_POLY  = 5'h13;
    localparam logic [8:0] GF256_POLY = 9'h11B;

    function automatic int unsigned ref_rnd(input int unsigned d);
        return (d * (d - 1)) / 2;
    endfunction

    function automatic int unsigned dom_rnd(input int unsigned d);
        return (d * (d - 1)) / 2;
    endfunction

    // Position of share pair (j,k), j<k, in the packed upper triangle.
    function automatic int unsigned pair_idx(input int unsigned j, input int unsigned k,
                                             input int unsigned d);
        return j * d - (j * (j + 1)) / 2 + (k - j - 1);
    endfunction

    function automatic int unsigned share_bit(input int unsigned l, input int unsigned i,
                                              input int unsigned j, input int unsigned w,
                                              input int unsigned d);
        return (l * w + i) * d + j;
    endfunction

endpackage

// File: rtl/msk_gf2n_dom_lane.sv
// One masked lane: pairwise refresh of b into stage 1, DOM product terms into
// stage 2, per-share XOR compression of the registered terms on the output.
module msk_gf2n_dom_lane
    import msk_gf_pkg::*;
#(
    parameter int unsigned D    = 2,
    parameter int unsigned W    = 4,
    parameter logic [W:0]  POLY = GF16_POLY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_s1,
    input  logic                         en_s2,
    input  logic [W*D-1:0]               a_i,
    input  logic [W*D-1:0]               b_i,
    input  logic [W*ref_rnd(D)-1:0]      rnd_ref_i,
    input  logic [W*dom_rnd(D)-1:0]      rnd_mul_i,
    output logic [W*D-1:0]               c_o
);

    localparam int unsigned RR = ref_rnd(D);
    localparam int unsigned RM = dom_rnd(D);

    logic [D-1:0][W-1:0]         a_sh;
    logic [D-1:0][W-1:0]         b_ref_d;
    logic [D-1:0][W-1:0]         a_s1_q;
    logic [D-1:0][W-1:0]         b_s1_q;
    logic [D-1:0][D-1:0][W-1:0]  dom_d;
    logic [D-1:0][D-1:0][W-1:0]  dom_q;
    logic [D-1:0][W-1:0]         c_sh;

    // Shift-and-reduce multiply; reduction is linear so it is applied share-wise.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] acc;
        logic [W-1:0] t;
        acc = '0;
        t   = x;
        for (int unsigned i = 0; i < W; i++) begin
            if (y[i]) acc = acc ^ t;
            t = {t[W-2:0], 1'b0} ^ (t[W-1] ? POLY[W-1:0] : '0);
        end
        return acc;
    endfunction

    always_comb begin
        a_sh    = '0;
        b_ref_d = '0;
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned i = 0; i < W; i++) begin
                a_sh[j][i]    = a_i[share_bit(0, i, j, W, D)];
                b_ref_d[j][i] = b_i[share_bit(0, i, j, W, D)];
            end
        end
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned k = j + 1; k < D; k++) begin
                for (int unsigned i = 0; i < W; i++) begin
                    b_ref_d[j][i] = b_ref_d[j][i] ^ rnd_ref_i[i*RR + pair_idx(j, k, D)];
                    b_ref_d[k][i] = b_ref_d[k][i] ^ rnd_ref_i[i*RR + pair_idx(j, k, D)];
                end
            end
        end
    end

    // Cross terms (j,k) and (k,j) share one random so the mask cancels on unmasking.
    always_comb begin
        dom_d = '0;
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned k = 0; k < D; k++) begin
                dom_d[j][k] = gf_mul(a_s1_q[j], b_s1_q[k]);
                if (j != k) begin
                    for (int unsigned i = 0; i < W; i++) begin
                        dom_d[j][k][i] = dom_d[j][k][i] ^
                            rnd_mul_i[i*RM + ((j < k) ? pair_idx(j, k, D) : pair_idx(k, j, D))];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q <= '0;
            b_s1_q <= '0;
            dom_q  <= '0;
        end else begin
            if (en_s1) begin
                a_s1_q <= a_sh;
                b_s1_q <= b_ref_d;
            end
            if (en_s2) begin
                dom_q <= dom_d;
            end
        end
    end

    always_comb begin
        c_sh = '0;
        c_o  = '0;
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned k = 0; k < D; k++) begin
                c_sh[j] = c_sh[j] ^ dom_q[j][k];
            end
        end
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned i = 0; i < W; i++) begin
                c_o[share_bit(0, i, j, W, D)] = c_sh[j][i];
            end
        end
    end

endmodule

// File: rtl/msk_gf2n_mul_hpc1_pipe.sv
// HPC1 masked GF(2^W) multiplier array (PINI at order d-1, randomness drawn
// only when a stage advances): valid/ready control plus one DOM lane per product.
module msk_gf2n_mul_hpc1_pipe
    import msk_gf_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned W       = 4,
    parameter logic [W:0]  POLY    = GF16_POLY,
    parameter int unsigned N_LANES = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_LANES*W*d-1:0]            in_a,
    input  logic [N_LANES*W*d-1:0]            in_b,
    input  logic [N_LANES*W*ref_rnd(d)-1:0]   rnd_ref,
    output logic                              rnd_ref_use,
    input  logic [N_LANES*W*dom_rnd(d)-1:0]   rnd_mul,
    output logic                              rnd_mul_use,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_LANES*W*d-1:0]            out_c
);

    localparam int unsigned REF_RND = ref_rnd(d);
    localparam int unsigned DOM_RND = dom_rnd(d);

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    // s1_adv is gated by rst_n so no randomness is reported consumed during reset.
    always_comb begin
        s2_adv     = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready   = ~s1_valid_q | s2_adv;
        s1_adv     = rst_n & in_valid & in_ready;
        s1_valid_d = s1_adv | (s1_valid_q & ~s2_adv);
        s2_valid_d = s2_adv | (s2_valid_q & ~out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign rnd_ref_use = s1_adv;
    assign rnd_mul_use = s2_adv;
    assign out_valid   = s2_valid_q;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        msk_gf2n_dom_lane #(
            .D    (d),
            .W    (W),
            .POLY (POLY)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_s1     (s1_adv),
            .en_s2     (s2_adv),
            .a_i       (in_a[l*W*d +: W*d]),
            .b_i       (in_b[l*W*d +: W*d]),
            .rnd_ref_i (rnd_ref[l*W*REF_RND +: W*REF_RND]),
            .rnd_mul_i (rnd_mul[l*W*DOM_RND +: W*DOM_RND]),
            .c_o       (out_c[l*W*d +: W*d])
        );
    end

endmodule

// File: tb/tb_msk_gf2n_mul_hpc1_pipe.sv
// Directed and exhaustive checks of the masked multiplier: GF(16)/d=2 single lane
// and GF(256)/d=3 dual lane, results unmasked and compared to a reference model.
module tb_msk_gf2n_mul_hpc1_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, rnd_ref_use0, rnd_mul_use0, out_valid0, out_ready0;
    logic [7:0]  in_a0, in_b0, out_c0;
    logic [3:0]  rnd_ref0, rnd_mul0;
    logic [3:0]  cur_a0, cur_b0;

    logic        in_valid1, in_ready1, rnd_ref_use1, rnd_mul_use1, out_valid1, out_ready1;
    logic [47:0] in_a1, in_b1, out_c1, rnd_ref1, rnd_mul1;

    msk_gf2n_mul_hpc1_pipe dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .rnd_ref(rnd_ref0), .rnd_ref_use(rnd_ref_use0),
        .rnd_mul(rnd_mul0), .rnd_mul_use(rnd_mul_use0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_c(out_c0)
    );

    msk_gf2n_mul_hpc1_pipe #(.d(3), .W(8), .POLY(9'h11B), .N_LANES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .rnd_ref(rnd_ref1), .rnd_ref_use(rnd_ref_use1),
        .rnd_mul(rnd_mul1), .rnd_mul_use(rnd_mul_use1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_c(out_c1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [3:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Schoolbook product followed by top-down reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input int w, input logic [8:0] poly);
        logic [15:0] p;
        logic [15:0] pp;
        p  = '0;
        pp = {7'd0, poly};
        for (int i = 0; i < w; i++) if (b[i]) p = p ^ ({8'd0, a} << i);
        for (int i = 2*w - 2; i >= w; i--) if (p[i]) p = p ^ (pp << (i - w));
        return p[7:0];
    endfunction

    function automatic logic [3:0] exp_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        if (b == 4'd0) return 4'd0;
        if (b == 4'd1) return a;
        r = ref_mul({4'd0, a}, {4'd0, b}, 4, 9'h013);
        return r[3:0];
    endfunction

    function automatic logic [7:0] mask0(input logic [3:0] v);
        logic [7:0] r;
        logic s;
        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom_range(0, 1));
            r[i*2]   = s;
            r[i*2+1] = v[i] ^ s;
        end
        return r;
    endfunction

    function automatic logic [3:0] unm0(input logic [7:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = c[i*2] ^ c[i*2+1];
        return r;
    endfunction

    function automatic logic [23:0] mask1(input logic [7:0] v);
        logic [23:0] r;
        logic s0, s1;
        for (int i = 0; i < 8; i++) begin
            s0 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            r[i*3]   = s0;
            r[i*3+1] = s1;
            r[i*3+2] = v[i] ^ s0 ^ s1;
        end
        return r;
    endfunction

    function automatic logic [7:0] unm1(input logic [23:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = c[i*3] ^ c[i*3+1] ^ c[i*3+2];
        return r;
    endfunction

    task automatic drive0(input logic v, input logic [3:0] a, input logic [3:0] b);
        in_valid0 = v;
        cur_a0    = a;
        cur_b0    = b;
        in_a0     = mask0(a);
        in_b0     = mask0(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        rnd_ref0 = 4'($urandom);
        rnd_mul0 = 4'($urandom);
        rnd_ref1 = {16'($urandom), $urandom};
        rnd_mul1 = {16'($urandom), $urandom};
    end

    // Scoreboard: push on accepted input, pop on accepted output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid0 && out_ready0) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("sb_out", unm0(out_c0), exp_q.pop_front());
                    n_out++;
                end
            end
            if (in_valid0 && in_ready0) exp_q.push_back(exp_mul(cur_a0, cur_b0));
        end
    end

    initial begin
        int base;
        int idx;
        int guard;
        logic acc;
        logic [7:0] oc;
        logic [3:0] sa [3];
        logic [3:0] sb [3];
        sa = '{4'h3, 4'h9, 4'hF};
        sb = '{4'h5, 4'hE, 4'hF};

        rst_n = 1'b0;
        drive0(1'b1, 4'h0, 4'h0);
        out_ready0 = 1'b1;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
        rnd_ref0 = '0; rnd_mul0 = '0; rnd_ref1 = '0; rnd_mul1 = '0;
        repeat (2) step();
        chk("rst_in_ready0", in_ready0, 1);
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_out_c0", out_c0, 0);
        chk("rst_ref_use0", rnd_ref_use0, 0);
        chk("rst_mul_use0", rnd_mul_use0, 0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_out_c1", out_c1, 0);
        drive0(1'b0, 4'h0, 4'h0);
        rst_n = 1'b1;
        step();

        // 0x7 * 0xB = 0x4 in GF(16), two-cycle latency
        drive0(1'b1, 4'h7, 4'hB);
        step();
        drive0(1'b0, 4'h0, 4'h0);
        chk("lat_cycle1_valid", out_valid0, 0);
        step();
        chk("lat_cycle2_valid", out_valid0, 1);
        chk("gf16_7x11", unm0(out_c0), 4'h4);
        step();

        // GF(256), d=3, two lanes
        in_valid1 = 1'b1;
        in_a1 = {mask1(8'h01), mask1(8'h57)};
        in_b1 = {mask1(8'hC4), mask1(8'h83)};
        step();
        in_valid1 = 1'b0;
        step();
        chk("gf256_valid", out_valid1, 1);
        chk("gf256_lane0", unm1(out_c1[23:0]), 8'hC1);
        chk("gf256_lane1", unm1(out_c1[47:24]), 8'hC4);
        step();

        // Back-to-back 16 inputs
        base = n_out;
        for (int k = 0; k < 16; k++) begin
            drive0(1'b1, 4'(k), 4'($urandom_range(0, 15)));
            #1;
            chk("b2b_ref_use", rnd_ref_use0, 1);
            if (k >= 1) chk("b2b_mul_use", rnd_mul_use0, 1);
            if (k >= 2) chk("b2b_out_valid", out_valid0, 1);
            step();
        end
        drive0(1'b0, 4'h0, 4'h0);
        #1;
        chk("b2b_tail_mul_use", rnd_mul_use0, 1);
        chk("b2b_tail_valid0", out_valid0, 1);
        step();
        chk("b2b_tail_valid1", out_valid0, 1);
        step();
        chk("b2b_tail_valid2", out_valid0, 0);
        chk("b2b_count", n_out - base, 16);

        // Stall: out_ready low for 5 cycles with 3 inputs offered
        base = n_out;
        out_ready0 = 1'b0;
        idx = 0;
        oc = '0;
        drive0(1'b1, sa[0], sb[0]);
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 2) oc = out_c0;
            if (c >= 2) begin
                chk("stall_in_ready", in_ready0, 0);
                chk("stall_out_valid", out_valid0, 1);
                chk("stall_ref_use", rnd_ref_use0, 0);
                chk("stall_mul_use", rnd_mul_use0, 0);
                chk("stall_out_c_stable", out_c0, oc);
            end
            acc = in_valid0 && in_ready0;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) drive0(1'b1, sa[idx], sb[idx]);
                else         drive0(1'b0, 4'h0, 4'h0);
            end
        end
        chk("stall_accepted", idx, 2);
        out_ready0 = 1'b1;
        guard = 0;
        while (idx < 3 && guard < 10) begin
            #1;
            acc = in_valid0 && in_ready0;
            step();
            guard++;
            if (acc) begin
                idx++;
                drive0(1'b0, 4'h0, 4'h0);
            end
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("stall_drain_count", n_out - base, 3);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Reset with both stages full
        out_ready0 = 1'b0;
        drive0(1'b1, 4'h2, 4'h3);
        step();
        drive0(1'b1, 4'h6, 4'h7);
        step();
        drive0(1'b0, 4'h0, 4'h0);
        #1;
        chk("full_out_valid", out_valid0, 1);
        chk("full_in_ready", in_ready0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid0, 0);
        chk("midrst_in_ready", in_ready0, 1);
        chk("midrst_out_c", out_c0, 0);
        chk("midrst_mul_use", rnd_mul_use0, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        out_ready0 = 1'b1;
        step();
        base = n_out;
        drive0(1'b1, 4'hA, 4'h3);
        step();
        drive0(1'b0, 4'h0, 4'h0);
        chk("postrst_cycle1_valid", out_valid0, 0);
        step();
        chk("postrst_cycle2_valid", out_valid0, 1);
        step();
        chk("postrst_count", n_out - base, 1);

        // Exhaustive GF(16) with random output back-pressure
        base = n_out;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive0(1'b1, 4'(a), 4'(b));
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 20) begin
                    out_ready0 = ($urandom_range(0, 3) != 0);
                    #1;
                    acc = in_ready0;
                    step();
                    guard++;
                end
                chk("exh_accept", acc, 1);
            end
        end
        drive0(1'b0, 4'h0, 4'h0);
        out_ready0 = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("exh_count", n_out - base, 256);
        chk("exh_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
